// File: rtl/ws_timing_pkg.sv
// Shared timing definitions for the WS2812B driver: mode and state encodings
// plus the nanosecond-to-cycle conversion used by timer, shifter and controller.
package ws_timing_pkg;

  typedef enum logic [1:0] {
    WS_MODE_RET  = 2'b00,
    WS_MODE_T0H  = 2'b01,
    WS_MODE_T1H  = 2'b10,
    WS_MODE_TBIT = 2'b11
  } ws_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ws_state_t;

  // Clock is reduced to MHz first so the intermediate product stays small;
  // very short intervals still last at least one cycle.
  function automatic int unsigned ns_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned ns);
    longint unsigned cyc;
    cyc = ((clk_hz / 64'd1_000_000) * ns) / 64'd1000;
    if (cyc == 64'd0) cyc = 64'd1;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/ws_limit_sel.sv
// Maps the latched interval mode onto its terminal count (N-1); also rejects
// parameter sets whose longest interval does not fit the counter width.
module ws_limit_sel
  import ws_timing_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned RET_NS  = 60_000,
  parameter int unsigned T0H_NS  = 400,
  parameter int unsigned T1H_NS  = 800,
  parameter int unsigned TBIT_NS = 1_250,
  parameter int unsigned CNT_W   = 14
) (
  input  ws_mode_t         mode,
  output logic [CNT_W-1:0] limit
);

  localparam int unsigned N_RET  = ns_to_cycles(64'(CLK_HZ), 64'(RET_NS));
  localparam int unsigned N_T0H  = ns_to_cycles(64'(CLK_HZ), 64'(T0H_NS));
  localparam int unsigned N_T1H  = ns_to_cycles(64'(CLK_HZ), 64'(T1H_NS));
  localparam int unsigned N_TBIT = ns_to_cycles(64'(CLK_HZ), 64'(TBIT_NS));
  localparam longint unsigned MAX_CNT = (64'd1 << CNT_W) - 64'd1;

  if (64'(N_RET) > MAX_CNT || 64'(N_T0H) > MAX_CNT ||
      64'(N_T1H) > MAX_CNT || 64'(N_TBIT) > MAX_CNT) begin : g_range_err
    $error("ws_limit_sel: interval cycle count exceeds CNT_W capacity");
  end

  always_comb begin
    limit = '0;
    case (mode)
      WS_MODE_RET:  limit = CNT_W'(N_RET - 1);
      WS_MODE_T0H:  limit = CNT_W'(N_T0H - 1);
      WS_MODE_T1H:  limit = CNT_W'(N_T1H - 1);
      WS_MODE_TBIT: limit = CNT_W'(N_TBIT - 1);
      default:      limit = CNT_W'(N_RET - 1);
    endcase
  end

endmodule

// File: rtl/ws_interval_timer.sv
// Interval timer pacing the WS2812B data line: start/done handshake, abort and
// auto-repeat. Define WS_TIMER_HOLD_EN to add the hold (counter freeze) input.
module ws_interval_timer
  import ws_timing_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned RET_NS  = 60_000,
  parameter int unsigned T0H_NS  = 400,
  parameter int unsigned T1H_NS  = 800,
  parameter int unsigned TBIT_NS = 1_250,
  parameter int unsigned CNT_W   = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             repeat_en,
  input  logic             abort,
`ifdef WS_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  ws_state_t        state;
  ws_state_t        state_next;
  ws_mode_t         mode_q;
  logic [CNT_W-1:0] limit;
  logic             at_limit;
  logic             frozen;
  logic             launch;

`ifdef WS_TIMER_HOLD_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  assign at_limit = (count == limit);
  assign launch   = (state == ST_IDLE) && start && !abort;

  ws_limit_sel #(
    .CLK_HZ  (CLK_HZ),
    .RET_NS  (RET_NS),
    .T0H_NS  (T0H_NS),
    .T1H_NS  (T1H_NS),
    .TBIT_NS (TBIT_NS),
    .CNT_W   (CNT_W)
  ) u_limit_sel (
    .mode  (mode_q),
    .limit (limit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = ST_RUN;
      ST_RUN: begin
        if (abort)                  state_next = ST_IDLE;
        else if (done && !repeat_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A frozen counter sits on its terminal value without signalling done.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_RUN) && at_limit && !frozen;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          count <= '0;
    else if (state != ST_RUN || abort)   count <= '0;
    else if (frozen)                     count <= count;
    else if (at_limit)                   count <= '0;
    else                                 count <= count + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mode_q <= WS_MODE_RET;
    else if (launch) mode_q <= ws_mode_t'(mode);
  end

endmodule

// File: tb/tb_ws_interval_timer.sv
// Directed self-checking bench for ws_interval_timer at 100 MHz defaults.
// Hold scenario is compiled in only when WS_TIMER_HOLD_EN is defined.
module tb_ws_interval_timer;

  localparam int CNT_W = 14;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic             repeat_en;
  logic             abort;
`ifdef WS_TIMER_HOLD_EN
  logic             hold;
`endif
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int vectors;
  int miscompares;

  ws_interval_timer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .repeat_en (repeat_en),
    .abort     (abort),
`ifdef WS_TIMER_HOLD_EN
    .hold      (hold),
`endif
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Pulses start for one cycle; afterwards the timer is in RUN with count 0.
  task automatic applyStimulus(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int width, output int dones,
                          output int lastDoneCount);
    width = 0;
    dones = 0;
    lastDoneCount = -1;
    while (busy && width < budget) begin
      if (done) begin
        dones++;
        lastDoneCount = int'(count);
      end
      width++;
      @(negedge clk);
    end
    if (busy) checkOutput("wait_timeout", 1, 0);
  endtask

  initial begin
    int width, dones, lastCnt, doneCnt, drops;
    int expWidth [3];
    vectors = 0;
    miscompares = 0;
    expWidth[0] = 40;
    expWidth[1] = 80;
    expWidth[2] = 125;
    reset = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    repeat_en = 1'b0;
    abort = 1'b0;
`ifdef WS_TIMER_HOLD_EN
    hold = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_count", int'(count), 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] RET interval");
    applyStimulus(2'b00);
    checkOutput("ret_busy_start", int'(busy), 1);
    checkOutput("ret_count_start", int'(count), 0);
    waitIdle(7000, width, dones, lastCnt);
    checkOutput("ret_width", width, 6000);
    checkOutput("ret_dones", dones, 1);
    checkOutput("ret_done_count", lastCnt, 5999);
    checkOutput("ret_idle_count", int'(count), 0);

    $display("[TB] T0H/T1H/TBIT intervals");
    for (int m = 1; m <= 3; m++) begin
      applyStimulus(2'(m));
      waitIdle(200, width, dones, lastCnt);
      checkOutput("mode_width", width, expWidth[m-1]);
      checkOutput("mode_dones", dones, 1);
      checkOutput("mode_done_count", lastCnt, expWidth[m-1] - 1);
      checkOutput("mode_idle_count", int'(count), 0);
    end

    $display("[TB] auto-repeat TBIT");
    repeat_en = 1'b1;
    applyStimulus(2'b11);
    doneCnt = 0;
    drops = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 375) repeat_en = 1'b0;
      if (!busy) drops++;
      if (i == 125) checkOutput("rep_reload_count", int'(count), 0);
      if (done) begin
        doneCnt++;
        checkOutput("rep_done_pos", i % 125, 124);
      end
      @(negedge clk);
    end
    checkOutput("rep_done_total", doneCnt, 4);
    checkOutput("rep_busy_drops", drops, 0);
    checkOutput("rep_idle_after", int'(busy), 0);

    $display("[TB] abort");
    applyStimulus(2'b10);
    doneCnt = 0;
    repeat (20) begin
      if (done) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort_pre_count", int'(count), 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_count", int'(count), 0);
    checkOutput("abort_no_done", doneCnt + int'(done), 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_start_idle", int'(busy), 0);
    @(negedge clk);
    checkOutput("abort_start_idle2", int'(busy), 0);

    repeat_en = 1'b1;
    applyStimulus(2'b01);
    repeat (39) @(negedge clk);
    abort = 1'b1;
    checkOutput("abort_done_pulse", int'(done), 1);
    @(negedge clk);
    abort = 1'b0;
    repeat_en = 1'b0;
    checkOutput("abort_done_idle", int'(busy), 0);

    $display("[TB] reset mid-interval");
    applyStimulus(2'b00);
    repeat (3000) @(negedge clk);
    checkOutput("rst_pre_count", int'(count), 3000);
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_count", int'(count), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] start ignored while running");
    applyStimulus(2'b10);
    repeat (10) @(negedge clk);
    applyStimulus(2'b01);
    checkOutput("restart_count", int'(count), 11);
    waitIdle(200, width, dones, lastCnt);
    checkOutput("restart_width", width, 69);
    checkOutput("restart_dones", dones, 1);
    checkOutput("restart_done_count", lastCnt, 79);

`ifdef WS_TIMER_HOLD_EN
    $display("[TB] hold mid-T0H");
    applyStimulus(2'b01);
    repeat (10) @(negedge clk);
    hold = 1'b1;
    doneCnt = 0;
    drops = 0;
    repeat (10) begin
      if (!busy) drops++;
      if (done) doneCnt++;
      @(negedge clk);
    end
    hold = 1'b0;
    checkOutput("hold_count", int'(count), 10);
    checkOutput("hold_busy_drops", drops, 0);
    waitIdle(200, width, dones, lastCnt);
    checkOutput("hold_total_width", width + 20, 50);
    checkOutput("hold_dones", dones + doneCnt, 1);
    checkOutput("hold_done_count", lastCnt, 39);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
